// File: rtl/instr_mem_responder.sv
// Instruction-side responder: program RAM preloaded over a streaming load port,
// then serves registered 1-cycle-latency fetches to the core.
module instr_mem_responder #(
  parameter int ADDRESS     = 32,
  parameter int INSTRUCTION = 32,
  parameter int DEPTH       = 256,
  parameter logic [INSTRUCTION-1:0] NOP_INSTR = 32'h00000013
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   load_valid_i,
  input  logic [INSTRUCTION-1:0] load_data_i,
  input  logic                   load_last_i,
  output logic                   load_ready_o,
  output logic                   load_overflow_o,
  input  logic [ADDRESS-1:0]     addr_i,
  output logic [INSTRUCTION-1:0] instr_o,
  output logic                   instr_valid_o,
  output logic                   fetch_err_o,
  output logic                   state_dbg
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int PTR_W = IDX_W + 1;

  // Load handshake: a beat transfers on any cycle with load_valid_i=1 while
  // load_ready_o=1; load_last_i is only meaningful on such a beat.
  typedef enum logic {LOAD = 1'b0, RUN = 1'b1} state_t;

  state_t                 state_q, state_d;
  logic [PTR_W-1:0]       load_ptr;
  logic                   ptr_full;
  logic                   load_beat;
  logic [INSTRUCTION-1:0] mem [DEPTH];
  logic [INSTRUCTION-1:0] rd_data;
  logic [IDX_W-1:0]       fetch_idx;
  logic                   misaligned;
  logic                   out_of_range;

  assign state_dbg = state_q;
  assign ptr_full  = (load_ptr == PTR_W'(DEPTH));
  assign load_beat = (state_q == LOAD) && load_valid_i;

  always_comb begin
    state_d      = state_q;
    load_ready_o = 1'b0;
    case (state_q)
      LOAD: begin
        load_ready_o = 1'b1;
        if (load_valid_i && load_last_i) state_d = RUN;
      end
      RUN: state_d = RUN;
      default: state_d = LOAD;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= LOAD;
    else     state_q <= state_d;
  end

  // Pointer saturates at DEPTH so a runaway stream can never wrap onto word 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      load_ptr        <= '0;
      load_overflow_o <= 1'b0;
    end else if (load_beat) begin
      if (ptr_full) load_overflow_o <= 1'b1;
      else          load_ptr        <= load_ptr + 1'b1;
    end
  end

  // RAM has no reset; reset only blocks a coincident write.
  always_ff @(posedge clk) begin
    if (!rst && load_beat && !ptr_full) mem[load_ptr[IDX_W-1:0]] <= load_data_i;
  end

  assign fetch_idx    = addr_i[IDX_W+1:2];
  assign misaligned   = |addr_i[1:0];
  assign out_of_range = |addr_i[ADDRESS-1:IDX_W+2];

  always_ff @(posedge clk) begin
    rd_data <= mem[fetch_idx];
  end

  always_ff @(posedge clk) begin
    if (rst || state_q != RUN) begin
      instr_valid_o <= 1'b0;
      fetch_err_o   <= 1'b0;
    end else begin
      instr_valid_o <= 1'b1;
      fetch_err_o   <= misaligned | out_of_range;
    end
  end

  // Registered RAM word is substituted with NOP when no valid fetch data exists.
  assign instr_o = (instr_valid_o && !fetch_err_o) ? rd_data : NOP_INSTR;

endmodule

// File: tb/tb_instr_mem_responder.sv
// Directed bench for instr_mem_responder: load, fetch, error, overflow and reset cases.
module tb_instr_mem_responder;

  localparam logic [31:0] NOP = 32'h00000013;

  logic        clk;
  logic        rst;
  logic        load_valid_i;
  logic [31:0] load_data_i;
  logic        load_last_i;
  logic        load_ready_o;
  logic        load_overflow_o;
  logic [31:0] addr_i;
  logic [31:0] instr_o;
  logic        instr_valid_o;
  logic        fetch_err_o;
  logic        state_dbg;

  int n_checks = 0;
  int n_fail   = 0;

  instr_mem_responder dut (
    .clk             (clk),
    .rst             (rst),
    .load_valid_i    (load_valid_i),
    .load_data_i     (load_data_i),
    .load_last_i     (load_last_i),
    .load_ready_o    (load_ready_o),
    .load_overflow_o (load_overflow_o),
    .addr_i          (addr_i),
    .instr_o         (instr_o),
    .instr_valid_o   (instr_valid_o),
    .fetch_err_o     (fetch_err_o),
    .state_dbg       (state_dbg)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // driver tasks
  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  task automatic load_word(input logic [31:0] data, input logic last);
    load_valid_i = 1'b1;
    load_data_i  = data;
    load_last_i  = last;
    step();
    load_valid_i = 1'b0;
    load_last_i  = 1'b0;
  endtask

  task automatic fetch(input string tag, input logic [31:0] addr,
                       input logic [31:0] exp_instr, input logic exp_err);
    addr_i = addr;
    step();
    check({tag, "_instr"}, instr_o, exp_instr);
    check({tag, "_err"},   32'(fetch_err_o), 32'(exp_err));
    check({tag, "_valid"}, 32'(instr_valid_o), 32'd1);
  endtask

  logic [31:0] a_words [4] = '{32'hA0A0_0000, 32'hA1A1_1111, 32'hA2A2_2222, 32'hA3A3_3333};
  logic [31:0] b_words [4] = '{32'hB0B0_0000, 32'hB1B1_1111, 32'hB2B2_2222, 32'hB3B3_3333};

  initial begin
    rst = 1'b0; load_valid_i = 1'b0; load_data_i = '0; load_last_i = 1'b0; addr_i = '0;
    #2;
    do_reset();

    // reset state
    check("rst_ready",    32'(load_ready_o), 32'd1);
    check("rst_valid",    32'(instr_valid_o), 32'd0);
    check("rst_err",      32'(fetch_err_o), 32'd0);
    check("rst_ovf",      32'(load_overflow_o), 32'd0);
    check("rst_instr",    instr_o, NOP);

    // load A0..A3, last beat on A3
    for (int i = 0; i < 4; i++) begin
      load_word(a_words[i], i == 3);
      check("load_valid_low", 32'(instr_valid_o), 32'd0);
    end
    check("run_ready", 32'(load_ready_o), 32'd0);
    for (int i = 0; i < 4; i++) fetch("fetch_a", 32'(4 * i), a_words[i], 1'b0);

    // misaligned fetches
    fetch("mis2", 32'h2, NOP, 1'b1);
    fetch("mis1", 32'h5, NOP, 1'b1);
    fetch("after_mis", 32'h8, a_words[2], 1'b0);

    // load beats in RUN are ignored
    load_valid_i = 1'b1; load_data_i = 32'hDEAD_BEEF; load_last_i = 1'b1;
    addr_i = 32'h0;
    step();
    check("run_ready_pulse", 32'(load_ready_o), 32'd0);
    load_valid_i = 1'b0; load_last_i = 1'b0;
    fetch("run_ignore", 32'h0, a_words[0], 1'b0);

    // reset in RUN
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("rrst_valid", 32'(instr_valid_o), 32'd0);
    check("rrst_ready", 32'(load_ready_o), 32'd1);
    check("rrst_instr", instr_o, NOP);

    // partial load, reset coinciding with a last beat, then reload
    load_word(32'hCCCC_0000, 1'b0);
    load_word(32'hCCCC_1111, 1'b0);
    rst = 1'b1; load_valid_i = 1'b1; load_data_i = 32'hEEEE_EEEE; load_last_i = 1'b1;
    step();
    rst = 1'b0; load_valid_i = 1'b0; load_last_i = 1'b0;
    check("rst_beat_ready", 32'(load_ready_o), 32'd1);
    for (int i = 0; i < 4; i++) load_word(b_words[i], i == 3);
    for (int i = 0; i < 4; i++) fetch("fetch_b", 32'(4 * i), b_words[i], 1'b0);

    // overflow: 257 beats
    do_reset();
    for (int i = 0; i < 256; i++) load_word(32'hC000_0000 + 32'(i), 1'b0);
    check("ovf_before", 32'(load_overflow_o), 32'd0);
    check("ovf_ready", 32'(load_ready_o), 32'd1);
    load_word(32'h5555_AAAA, 1'b1);
    check("ovf_after", 32'(load_overflow_o), 32'd1);
    fetch("ovf_word0", 32'h0, 32'hC000_0000, 1'b0);
    fetch("range_top", 32'h3FC, 32'hC000_00FF, 1'b0);
    fetch("range_out", 32'h400, NOP, 1'b1);
    fetch("range_high", 32'h8000_0000, NOP, 1'b1);
    fetch("range_back", 32'h10, 32'hC000_0004, 1'b0);
    check("ovf_sticky", 32'(load_overflow_o), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
